time_of_day_counter: RTL and testbench

- Consumes the divided `second_clk` from the prescaler stage and maintains the hours:minutes:seconds time of day.
- Runs synchronously on the `clk` domain. The prescaler output is treated as an asynchronous level: it is synchronised, and each rising edge becomes a one-cycle tick.
- Supports manual setting of hours and minutes from the `time_set` switches, and run/stop gating via `clock_on`.
- Drives the 17-bit LED field `{hours, minutes, seconds}` consumed by the top level.

---
 rtl/clock_pkg.sv | 17 +
 rtl/sync_edge_detect.sv | 34 +++
 rtl/time_of_day_counter.sv | 115 +++++++++++
 tb/tb_time_of_day_counter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared widths and limits for the time-of-day counter slice.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int LED_W  = 17;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Saturate a loaded switch value to the largest legal field value.
  function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser on an asynchronous level plus a one-cycle
// rising-edge pulse. Usable for the prescaler output or set buttons.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the level through the synchroniser and remember the last stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-history state; reset discards any pending edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/time_of_day_counter.sv
// Hours:minutes:seconds counter advanced by the synchronised 1 Hz
// prescaler edge, with switch loading and run/stop gating.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int HOUR_MODULUS = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              second_clk,
  input  logic              clock_on,
  input  logic              hour_set,
  input  logic              minute_set,
  input  logic [5:0]        time_set,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic              min_carry,
  output logic              hour_carry,
  output logic              day_rollover,
  output logic [LED_W-1:0]  leds
);

  localparam logic [5:0]        HOUR_MAX   = 6'(HOUR_MODULUS - 1);
  localparam logic [HOUR_W-1:0] HOUR_MAX_H = HOUR_W'(HOUR_MODULUS - 1);

  logic              tick;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              min_carry_q, min_carry_d;
  logic              hour_carry_q, hour_carry_d;
  logic              day_rollover_q, day_rollover_d;
  logic [LED_W-1:0]  leds_q, leds_d;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_second_edge (
    .clk (clk),
    .rstn(rstn),
    .din (second_clk),
    .tick(tick)
  );

  // Loads take priority over counting, so a tick during a set is dropped;
  // the full carry chain resolves in a single cycle.
  always_comb begin
    sec_d          = sec_q;
    min_d          = min_q;
    hour_d         = hour_q;
    min_carry_d    = 1'b0;
    hour_carry_d   = 1'b0;
    day_rollover_d = 1'b0;
    leds_d         = {hour_q, min_q, sec_q};
    if (hour_set || minute_set) begin
      if (hour_set) begin
        hour_d = HOUR_W'(clamp6(time_set, HOUR_MAX));
      end
      if (minute_set) begin
        min_d = clamp6(time_set, MIN_MAX);
        sec_d = '0;
      end
    end else if (tick && clock_on) begin
      if (sec_q >= SEC_MAX) begin
        sec_d       = '0;
        min_carry_d = 1'b1;
        if (min_q >= MIN_MAX) begin
          min_d        = '0;
          hour_carry_d = 1'b1;
          if (hour_q >= HOUR_MAX_H) begin
            hour_d         = '0;
            day_rollover_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Counter, pulse and LED registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sec_q          <= '0;
      min_q          <= '0;
      hour_q         <= '0;
      min_carry_q    <= 1'b0;
      hour_carry_q   <= 1'b0;
      day_rollover_q <= 1'b0;
      leds_q         <= '0;
    end else begin
      sec_q          <= sec_d;
      min_q          <= min_d;
      hour_q         <= hour_d;
      min_carry_q    <= min_carry_d;
      hour_carry_q   <= hour_carry_d;
      day_rollover_q <= day_rollover_d;
      leds_q         <= leds_d;
    end
  end

  assign seconds      = sec_q;
  assign minutes      = min_q;
  assign hours        = hour_q;
  assign min_carry    = min_carry_q;
  assign hour_carry   = hour_carry_q;
  assign day_rollover = day_rollover_q;
  assign leds         = leds_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Randomised and directed bench for time_of_day_counter against a
// seconds-of-day reference model.
module tb_time_of_day_counter;

  localparam int HM  = 24;
  localparam int DAY = HM * 3600;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        second_clk = 1'b0;
  logic        clock_on = 1'b0;
  logic        hour_set = 1'b0;
  logic        minute_set = 1'b0;
  logic [5:0]  time_set = 6'd0;
  logic [5:0]  seconds;
  logic [5:0]  minutes;
  logic [4:0]  hours;
  logic        min_carry;
  logic        hour_carry;
  logic        day_rollover;
  logic [16:0] leds;

  always #5 clk = ~clk;

  time_of_day_counter #(
    .SYNC_STAGES (2),
    .HOUR_MODULUS(HM)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .second_clk  (second_clk),
    .clock_on    (clock_on),
    .hour_set    (hour_set),
    .minute_set  (minute_set),
    .time_set    (time_set),
    .seconds     (seconds),
    .minutes     (minutes),
    .hours       (hours),
    .min_carry   (min_carry),
    .hour_carry  (hour_carry),
    .day_rollover(day_rollover),
    .leds        (leds)
  );

  // Reference model: time held as seconds since midnight.
  int         m_tod = 0;
  bit   [2:0] m_smp = 3'b000;   // second_clk samples at edges n-1, n-2, n-3
  bit   [2:0] m_p = 3'b000;     // {day_rollover, hour_carry, min_carry}
  logic [16:0] m_leds = '0;
  bit         mvalid = 1'b0;

  always @(posedge clk) begin : model
    int t, h, m, s, ts;
    bit tick;
    bit [2:0] p;
    if (!rstn) begin
      m_tod  <= 0;
      m_smp  <= 3'b000;
      m_p    <= 3'b000;
      m_leds <= '0;
      mvalid <= 1'b1;
    end else begin
      t = m_tod;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      m_leds <= 17'((h << 12) | (m << 6) | s);
      // A rise seen at edge k is acted on at edge k+2.
      tick = m_smp[1] & ~m_smp[2];
      m_smp <= {m_smp[1:0], second_clk};
      p = 3'b000;
      ts = int'(time_set);
      if (hour_set || minute_set) begin
        if (hour_set) h = (ts > HM - 1) ? HM - 1 : ts;
        if (minute_set) begin
          m = (ts > 59) ? 59 : ts;
          s = 0;
        end
        t = h * 3600 + m * 60 + s;
      end else if (tick && clock_on) begin
        t = (t + 1) % DAY;
        p = {t == 0, (t % 3600) == 0, (t % 60) == 0};
      end
      m_tod <= t;
      m_p   <= p;
    end
  end

  // Directed expectations posted by the stimulus, checked at the next negedge.
  int        req_id = 0;
  int        done_id = 0;
  string     exp_tag = "";
  bit  [5:0] exp_mask = '0;   // sec, min, hour, pulses, leds, min_carry count
  int        exp_s = 0, exp_m = 0, exp_h = 0, exp_p = 0, exp_l = 0, exp_mc = 0;

  int nvec = 0;
  int nerr = 0;
  int mc_total = 0;

  function automatic int miss(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      return 1;
    end
    return 0;
  endfunction

  always @(negedge clk) begin : compare
    int v, e;
    v = 0;
    e = 0;
    if (mvalid) begin
      v += 5;
      e += miss("seconds", 32'(seconds), 32'(m_tod % 60));
      e += miss("minutes", 32'(minutes), 32'((m_tod / 60) % 60));
      e += miss("hours", 32'(hours), 32'(m_tod / 3600));
      e += miss("pulses", 32'({day_rollover, hour_carry, min_carry}), 32'(m_p));
      e += miss("leds", 32'(leds), 32'(m_leds));
    end
    if (req_id != done_id) begin
      if (exp_mask[0]) begin v++; e += miss({exp_tag, ".sec"}, 32'(seconds), 32'(exp_s)); end
      if (exp_mask[1]) begin v++; e += miss({exp_tag, ".min"}, 32'(minutes), 32'(exp_m)); end
      if (exp_mask[2]) begin v++; e += miss({exp_tag, ".hour"}, 32'(hours), 32'(exp_h)); end
      if (exp_mask[3]) begin
        v++;
        e += miss({exp_tag, ".pulses"}, 32'({day_rollover, hour_carry, min_carry}), 32'(exp_p));
      end
      if (exp_mask[4]) begin v++; e += miss({exp_tag, ".leds"}, 32'(leds), 32'(exp_l)); end
      if (exp_mask[5]) begin v++; e += miss({exp_tag, ".mc_count"}, 32'(mc_total), 32'(exp_mc)); end
      done_id <= req_id;
    end
    nvec <= nvec + v;
    nerr <= nerr + e;
    mc_total <= mc_total + ((min_carry === 1'b1) ? 1 : 0);
  end

  task automatic want(input string tag, input bit [5:0] mask, input int h, input int m,
                      input int s, input int p, input int l, input int mc);
    exp_tag  = tag;
    exp_mask = mask;
    exp_h    = h;
    exp_m    = m;
    exp_s    = s;
    exp_p    = p;
    exp_l    = l;
    exp_mc   = mc;
    req_id++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sec(input int hi, input int lo);
    second_clk = 1'b1;
    wait_cycles(hi);
    second_clk = 1'b0;
    wait_cycles(lo);
  endtask

  task automatic load(input bit hs, input bit ms, input int v);
    hour_set   = hs;
    minute_set = ms;
    time_set   = 6'(v);
    wait_cycles(1);
    hour_set   = 1'b0;
    minute_set = 1'b0;
  endtask

  initial begin : stim
    int snap;
    // Reset held while the prescaler toggles.
    wait_cycles(1);
    second_clk = 1'b1; wait_cycles(2);
    second_clk = 1'b0; wait_cycles(2);
    second_clk = 1'b1; wait_cycles(1);
    second_clk = 1'b0; wait_cycles(1);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      want("reset", 6'b011111, 0, 0, 0, 0, 0, 0);
      wait_cycles(1);
    end

    // Basic count with exact latency on the first rise.
    clock_on = 1'b1;
    wait_cycles(1);
    snap = mc_total;
    second_clk = 1'b1;
    wait_cycles(2);
    want("latency_edge2", 6'b001001, 0, 0, 0, 0, 0, 0);
    wait_cycles(1);
    want("latency_edge3", 6'b001001, 0, 0, 1, 0, 0, 0);
    wait_cycles(1);
    second_clk = 1'b0;
    wait_cycles(4);
    for (int i = 0; i < 59; i++) pulse_sec(4, 4);
    want("minute_count", 6'b110111, 0, 1, 0, 0, 64, snap + 1);
    wait_cycles(1);

    // Day wrap with all carries together.
    load(1'b1, 1'b0, 23);
    load(1'b0, 1'b1, 59);
    for (int i = 0; i < 59; i++) pulse_sec(4, 4);
    want("pre_wrap", 6'b001111, 23, 59, 59, 0, 0, 0);
    second_clk = 1'b1;
    wait_cycles(3);
    want("day_wrap", 6'b001111, 0, 0, 0, 7, 0, 0);
    wait_cycles(1);
    want("post_wrap", 6'b011000, 0, 0, 0, 0, 0, 0);
    second_clk = 1'b0;
    wait_cycles(4);

    // Clamping of out-of-range loads.
    load(1'b1, 1'b0, 40);
    want("clamp_hour", 6'b001100, 23, 0, 0, 0, 0, 0);
    wait_cycles(1);
    load(1'b0, 1'b1, 63);
    want("clamp_min", 6'b001111, 23, 59, 0, 0, 0, 0);
    wait_cycles(1);

    // Hold while stopped, then exactly one step after re-enable.
    clock_on = 1'b0;
    for (int i = 0; i < 5; i++) pulse_sec(3, 3);
    want("hold", 6'b001111, 23, 59, 0, 0, 0, 0);
    wait_cycles(1);
    clock_on = 1'b1;
    pulse_sec(4, 4);
    want("resume", 6'b000111, 23, 59, 1, 0, 0, 0);
    wait_cycles(1);

    // Tick colliding with a minute load at 00:05:59.
    load(1'b1, 1'b0, 0);
    load(1'b0, 1'b1, 5);
    for (int i = 0; i < 59; i++) pulse_sec(4, 4);
    want("pre_collide", 6'b000111, 0, 5, 59, 0, 0, 0);
    second_clk = 1'b1;
    wait_cycles(2);
    minute_set = 1'b1;
    time_set = 6'd10;
    wait_cycles(1);
    want("collide", 6'b001111, 0, 10, 0, 0, 0, 0);
    minute_set = 1'b0;
    wait_cycles(1);
    second_clk = 1'b0;
    wait_cycles(4);
    pulse_sec(4, 4);
    pulse_sec(4, 4);
    want("pre_reset", 6'b000111, 0, 10, 2, 0, 0, 0);
    wait_cycles(1);
    rstn = 1'b0;
    wait_cycles(1);
    want("mid_reset", 6'b011111, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    wait_cycles(1);

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 19))
        0: begin
          rstn = 1'b0;
          wait_cycles(1);
          rstn = 1'b1;
        end
        1, 2: begin
          hour_set   = 1'($urandom_range(0, 1));
          minute_set = 1'($urandom_range(0, 1));
          time_set   = 6'($urandom_range(0, 63));
          wait_cycles($urandom_range(1, 3));
          hour_set   = 1'b0;
          minute_set = 1'b0;
        end
        3: clock_on = ~clock_on;
        4: begin
          load(1'b1, 1'b1, 59);
          clock_on = 1'b1;
        end
        default: pulse_sec($urandom_range(1, 5), $urandom_range(1, 5));
      endcase
    end

    wait_cycles(4);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
